wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and integer register file for the five-stage RV32I pipeline. It consumes the registered MEM/WB pipeline-latch outputs, selects and formats the writeback value, and commits it to a 32 x 32-bit register file. It serves the decode stage's two read ports with same-cycle write-first bypass and keeps a retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREGS, 32, register count; index width is 5

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears register file and counters
- RegWrite  in  1  writeback enable from MEM/WB latch
- MemtoReg  in  1  select load data (valid only when RWSel=00)
- RWSel  in  2  writeback source: 00 ALU/mem, 01 PC+4, 10 immediate, 11 PC+imm
- Pc_Imm  in  8  branch/AUIPC target, zero-extended on write
- Pc_Four  in  8  link address, zero-extended on write
- Imm_Out  in  32  LUI immediate
- Alu_Result  in  32  ALU result; bits [1:0] give the load byte offset
- MemReadData  in  32  raw aligned data-memory word
- rd  in  5  destination register
- Curr_Instr  in  32  instruction in WB; funct3 = [14:12]; all-zero = bubble
- rs1_addr, rs2_addr  in  5  decode-stage read addresses
- rs1_data, rs2_data  out  32  read data (combinational)
- WB_Data  out  32  formatted writeback value (combinational)
- WB_En  out  1  RegWrite && rd != 0 (combinational)
- retire_count  out  32  registered count of retired instructions

## Operation
- Write data select:
  - RWSel=00: MemtoReg ? load_fmt : Alu_Result
  - RWSel=01: {24'b0, Pc_Four}
  - RWSel=10: Imm_Out
  - RWSel=11: {24'b0, Pc_Imm}
- load_fmt by funct3, with off = Alu_Result[1:0]:
  - 000 LB: byte MemReadData[8*off+:8], sign-extended
  - 001 LH: half MemReadData[16*off[1]+:16], sign-extended
  - 010 LW: full word
  - 100 LBU: byte, zero-extended
  - 101 LHU: half, zero-extended
  - other: full word
  - Misaligned LH/LW (off[0]=1 for LH, off!=0 for LW): no trap; LH uses off[1] only, LW ignores offset.
- Write: on rising clk, if !reset and WB_En, then regs[rd] <= WB_Data.
- x0: always reads 0 and is never written. WB_En=0 whenever rd=0.
- Read: rsN_data = 0 if rsN_addr=0; else WB_Data if WB_En && rd==rsN_addr (write-first bypass); else regs[rsN_addr].
- Retire: retire_count increments by 1 at each clk when Curr_Instr != 0, independent of RegWrite, so stores and branches count. Wraps from FFFF_FFFF to 0.

## Timing
- Reset (synchronous): at the first rising clk with reset=1, all regs become 0 and retire_count becomes 0. Reset wins over a simultaneous write or retire.
- Until that first reset edge, register contents are undefined. The bench must apply reset for at least 1 cycle.
- Combinational outputs (rs1_data, rs2_data, WB_Data, WB_En) reflect inputs within the same cycle. Their reset value follows the cleared file: reads return 0 unless bypass applies.
- Write latency: a value is committed at the end of the WB cycle. Thanks to bypass, a decode-stage read in the same cycle sees it, with 0 effective latency.
- Both read ports may address the same register, and either may match rd at the same time; each is independently bypassed.
- retire_count is updated on the same edge as the register write.

## Test plan
- Reset then read all 32 regs -> every rs1_data/rs2_data = 0; retire_count = 0.
- RegWrite=1, RWSel=00, MemtoReg=0, rd=5, Alu_Result=0xDEADBEEF, Curr_Instr nonzero -> same cycle rs1_addr=5 reads 0xDEADBEEF (bypass); next cycle it reads 0xDEADBEEF from the file; retire_count = 1.
- Load formatting with MemReadData=0x80FF7F01:
  - LB, off=3 -> 0xFFFFFF80
  - LBU, off=1 -> 0x0000007F
  - LH, off=2 -> 0xFFFF80FF
  - LHU, off=0 -> 0x00007F01
- RWSel=01, Pc_Four=0x14, rd=1 -> x1 = 0x00000014. RWSel=11, Pc_Imm=0xF0 -> 0x000000F0. RWSel=10, Imm_Out=0x12345000 -> same value.
- Write with rd=0, Alu_Result=0xFFFFFFFF -> WB_En=0, x0 reads 0 in that cycle and the next; retire_count still increments.
- Assert reset in the same cycle as a write to x7=0xA5A5A5A5 with retire_count=10 -> x7 = 0 and retire_count = 0 afterwards. Then 3 bubble cycles (Curr_Instr=0) -> retire_count stays 0.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage and integer register file for a five-stage RV32I pipeline.
//
// Takes the registered MEM/WB latch outputs and selects the writeback value. For loads it
// also formats the data. The value is committed to a 32 x XLEN register file. The file serves
// two decode-stage read ports with same-cycle write-first bypass, and a retired-instruction
// counter is kept.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset (clears file and counter)
//   RegWrite          writeback enable from MEM/WB
//   MemtoReg          choose formatted load data when RWSel = 00
//   RWSel             00 ALU/mem, 01 PC+4, 10 immediate, 11 PC+imm
//   Pc_Imm, Pc_Four   8-bit target / link addresses, zero-extended on write
//   Imm_Out           LUI immediate
//   Alu_Result        ALU result; [1:0] is the load byte offset
//   MemReadData       raw aligned data-memory word
//   rd                destination register
//   Curr_Instr        instruction in WB; funct3 = [14:12]; all-zero marks a bubble
//   rs1_addr/rs2_addr decode-stage read addresses
//   rs1_data/rs2_data combinational read data (x0 = 0, bypassed from WB)
//   WB_Data, WB_En    combinational writeback value and effective write enable
//   retire_count      registered count of non-bubble instructions (wraps)

module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RegWrite,
   input  logic            MemtoReg,
   input  logic [1:0]      RWSel,
   input  logic [7:0]      Pc_Imm,
   input  logic [7:0]      Pc_Four,
   input  logic [XLEN-1:0] Imm_Out,
   input  logic [XLEN-1:0] Alu_Result,
   input  logic [XLEN-1:0] MemReadData,
   input  logic [4:0]      rd,
   input  logic [31:0]     Curr_Instr,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] WB_Data,
   output logic            WB_En,
   output logic [31:0]     retire_count
);

   logic [XLEN-1:0] regs_reg [NREGS];
   logic [31:0]     retire_reg;

   logic [2:0]      funct3;
   logic [1:0]      off;
   logic [7:0]      load_byte;
   logic [15:0]     load_half;
   logic [XLEN-1:0] load_fmt;

   assign funct3 = Curr_Instr[14:12];
   assign off    = Alu_Result[1:0];

   // The byte lane comes from the full offset. The halfword lane uses only off[1], so a
   // misaligned LH quietly reads the half that contains the addressed byte.
   assign load_byte = MemReadData[{off, 3'b000} +: 8];
   assign load_half = MemReadData[{off[1], 4'b0000} +: 16];

   always_comb begin
      load_fmt = MemReadData;
      case (funct3)
         3'b000:  load_fmt = {{(XLEN-8){load_byte[7]}}, load_byte};
         3'b001:  load_fmt = {{(XLEN-16){load_half[15]}}, load_half};
         3'b100:  load_fmt = {{(XLEN-8){1'b0}}, load_byte};
         3'b101:  load_fmt = {{(XLEN-16){1'b0}}, load_half};
         default: load_fmt = MemReadData;   // LW and unused encodings: whole word
      endcase
   end

   always_comb begin
      WB_Data = Alu_Result;
      case (RWSel)
         2'b00:   WB_Data = MemtoReg ? load_fmt : Alu_Result;
         2'b01:   WB_Data = {{(XLEN-8){1'b0}}, Pc_Four};
         2'b10:   WB_Data = Imm_Out;
         default: WB_Data = {{(XLEN-8){1'b0}}, Pc_Imm};
      endcase
   end

   // A write to x0 is suppressed here, so neither the file nor the bypass can expose it.
   assign WB_En = RegWrite && (rd != 5'd0);

   // Register file. Reset clears every entry, so it must live in flops rather than RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (WB_En) begin
         regs_reg[rd] <= WB_Data;
      end
   end

   // Read ports. The value being written this cycle wins over the stored copy, which gives
   // a same-cycle decode read zero effective latency.
   logic [4:0]      raddr [2];
   logic [XLEN-1:0] rdata [2];

   assign raddr[0] = rs1_addr;
   assign raddr[1] = rs2_addr;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_read
         assign rdata[gi] = (raddr[gi] == 5'd0)              ? '0      :
                            (WB_En && (rd == raddr[gi]))     ? WB_Data :
                                                               regs_reg[raddr[gi]];
      end
   endgenerate

   assign rs1_data = rdata[0];
   assign rs2_data = rdata[1];

   // Stores and branches count as retired too. Only an all-zero bubble is skipped.
   always_ff @(posedge clk) begin
      if (reset) begin
         retire_reg <= '0;
      end else if (Curr_Instr != 32'd0) begin
         retire_reg <= retire_reg + 32'd1;
      end
   end

   assign retire_count = retire_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- scoreboard bench for wb_regfile.
// The driver sets inputs 1 time unit after each rising edge and queues the outputs it expects
// in that cycle. A monitor pops the queue on every falling edge and compares it with the DUT.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite, MemtoReg;
   logic [1:0]  RWSel;
   logic [7:0]  Pc_Imm, Pc_Four;
   logic [31:0] Imm_Out, Alu_Result, MemReadData, Curr_Instr;
   logic [4:0]  rd, rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data, WB_Data, retire_count;
   logic        WB_En;

   always #5 clk = ~clk;

   wb_regfile #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RWSel(RWSel),
      .Pc_Imm(Pc_Imm), .Pc_Four(Pc_Four), .Imm_Out(Imm_Out), .Alu_Result(Alu_Result),
      .MemReadData(MemReadData), .rd(rd), .Curr_Instr(Curr_Instr),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .WB_Data(WB_Data), .WB_En(WB_En), .retire_count(retire_count)
   );

   localparam int K_RS1 = 0, K_RS2 = 1, K_WBD = 2, K_WBEN = 3, K_RET = 4;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t        q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] ret_exp;

   // Monitor: the outputs are combinational or already registered, so each queued
   // expectation is judged at the falling edge of the cycle that queued it.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         chk_t        c;
         logic [31:0] act;
         c = q.pop_front();
         case (c.kind)
            K_RS1:   act = rs1_data;
            K_RS2:   act = rs2_data;
            K_WBD:   act = WB_Data;
            K_WBEN:  act = {31'd0, WB_En};
            default: act = retire_count;
         endcase
         n_checks++;
         if (act !== c.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
         end else begin
            $display("ok   %s: %h", c.name, act);
         end
      end
   end

   task automatic push(input int kind, input logic [31:0] e, input string nm);
      chk_t c;
      c.kind = kind;
      c.exp  = e;
      c.name = nm;
      q.push_back(c);
   endtask

   // Advance one cycle and track the expected retire count across the edge.
   task automatic tick();
      @(posedge clk);
      if (reset)                   ret_exp = 32'd0;
      else if (Curr_Instr != 0)    ret_exp = ret_exp + 32'd1;
      #1;
   endtask

   int          f3s [10] = '{0, 4, 1, 5, 2, 2, 1, 0, 0, 6};
   int          offs[10] = '{3, 1, 2, 0, 0, 1, 3, 0, 2, 1};
   logic [31:0] lexp[10] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                             32'h80FF7F01, 32'h80FF7F01, 32'hFFFF80FF, 32'h00000001,
                             32'hFFFFFFFF, 32'h80FF7F01};

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      ret_exp = 32'd0;
      reset = 1'b1; RegWrite = 1'b0; MemtoReg = 1'b0; RWSel = 2'b00;
      Pc_Imm = 8'h00; Pc_Four = 8'h00; Imm_Out = 32'd0; Alu_Result = 32'd0;
      MemReadData = 32'd0; Curr_Instr = 32'd0; rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
      tick();
      tick();
      reset = 1'b0;

      // Every register reads zero after reset.
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         push(K_RS1, 32'd0, $sformatf("reset_rs1_x%0d", i));
         push(K_RS2, 32'd0, $sformatf("reset_rs2_x%0d", 31 - i));
         if (i == 0) push(K_RET, 32'd0, "reset_retire");
         tick();
      end

      // ALU writeback to x5: bypass in the same cycle, then a read from the file.
      RegWrite = 1'b1; RWSel = 2'b00; MemtoReg = 1'b0; rd = 5'd5;
      Alu_Result = 32'hDEADBEEF; Curr_Instr = 32'h00000013; rs1_addr = 5'd5; rs2_addr = 5'd0;
      push(K_RS1, 32'hDEADBEEF, "alu_bypass_x5");
      push(K_WBEN, 32'd1, "alu_wben");
      push(K_RET, 32'd0, "alu_retire_before");
      tick();
      RegWrite = 1'b0; Curr_Instr = 32'd0; rs1_addr = 5'd5; rs2_addr = 5'd5;
      push(K_RS1, 32'hDEADBEEF, "alu_file_rs1_x5");
      push(K_RS2, 32'hDEADBEEF, "alu_file_rs2_x5");
      push(K_RET, 32'd1, "alu_retire_after");
      tick();

      // Load formatting into x6 from a fixed memory word.
      RegWrite = 1'b1; MemtoReg = 1'b1; RWSel = 2'b00; rd = 5'd6; MemReadData = 32'h80FF7F01;
      rs1_addr = 5'd6; rs2_addr = 5'd5;
      for (int i = 0; i < 10; i++) begin
         Curr_Instr = 32'h00000003 | (32'(f3s[i]) << 12);
         Alu_Result = 32'h00001000 | 32'(offs[i]);
         push(K_WBD, lexp[i], $sformatf("load_f3_%0d_off_%0d", f3s[i], offs[i]));
         push(K_RS1, lexp[i], $sformatf("load_bypass_%0d", i));
         push(K_RET, ret_exp, $sformatf("load_retire_%0d", i));
         tick();
      end
      RegWrite = 1'b0; Curr_Instr = 32'd0;
      push(K_RS1, 32'h80FF7F01, "load_file_x6");
      push(K_RS2, 32'hDEADBEEF, "load_keep_x5");
      tick();

      // PC+4, PC+imm and immediate sources.
      RegWrite = 1'b1; MemtoReg = 1'b1; Curr_Instr = 32'h000000EF;
      RWSel = 2'b01; Pc_Four = 8'h14; Pc_Imm = 8'hAA; Imm_Out = 32'h55555555; rd = 5'd1;
      rs1_addr = 5'd1;
      push(K_WBD, 32'h00000014, "src_pc4");
      tick();
      RWSel = 2'b11; Pc_Imm = 8'hF0; rd = 5'd2; rs1_addr = 5'd2;
      push(K_WBD, 32'h000000F0, "src_pcimm");
      tick();
      RWSel = 2'b10; Imm_Out = 32'h12345000; rd = 5'd3; Curr_Instr = 32'h123450B7;
      rs1_addr = 5'd3;
      push(K_RS1, 32'h12345000, "src_imm_bypass");
      tick();
      RegWrite = 1'b0; Curr_Instr = 32'd0; rs1_addr = 5'd1; rs2_addr = 5'd2;
      push(K_RS1, 32'h00000014, "file_x1");
      push(K_RS2, 32'h000000F0, "file_x2");
      tick();
      rs1_addr = 5'd3; rs2_addr = 5'd3;
      push(K_RS1, 32'h12345000, "file_x3_rs1");
      push(K_RS2, 32'h12345000, "file_x3_rs2");
      tick();

      // A write to x0 is dropped, but the instruction still retires.
      RegWrite = 1'b1; MemtoReg = 1'b0; RWSel = 2'b00; rd = 5'd0; Alu_Result = 32'hFFFFFFFF;
      Curr_Instr = 32'h00000013; rs1_addr = 5'd0; rs2_addr = 5'd0;
      push(K_WBEN, 32'd0, "x0_wben");
      push(K_RS1, 32'd0, "x0_same_rs1");
      push(K_RS2, 32'd0, "x0_same_rs2");
      push(K_RET, ret_exp, "x0_retire_before");
      tick();
      RegWrite = 1'b0; Curr_Instr = 32'd0;
      push(K_RS1, 32'd0, "x0_next_rs1");
      push(K_RET, ret_exp, "x0_retire_after");
      tick();

      // Both ports bypass together. With RegWrite low, the bypass must not fire.
      RegWrite = 1'b1; rd = 5'd9; Alu_Result = 32'h0BADF00D; Curr_Instr = 32'h00000033;
      rs1_addr = 5'd9; rs2_addr = 5'd9;
      push(K_RS1, 32'h0BADF00D, "dual_bypass_rs1");
      push(K_RS2, 32'h0BADF00D, "dual_bypass_rs2");
      tick();
      RegWrite = 1'b0; rd = 5'd5; Alu_Result = 32'h11111111; rs1_addr = 5'd5; rs2_addr = 5'd9;
      push(K_RS1, 32'hDEADBEEF, "no_write_no_bypass");
      push(K_WBEN, 32'd0, "no_write_wben");
      push(K_RS2, 32'h0BADF00D, "file_x9");
      tick();

      // Reset, count ten retirements, then reset again during a write to x7.
      reset = 1'b1; Curr_Instr = 32'd0;
      tick();
      reset = 1'b0; Curr_Instr = 32'h00000013;
      for (int i = 0; i < 10; i++) begin
         push(K_RET, 32'(i), $sformatf("count_up_%0d", i));
         tick();
      end
      reset = 1'b1; RegWrite = 1'b1; RWSel = 2'b00; MemtoReg = 1'b0; rd = 5'd7;
      Alu_Result = 32'hA5A5A5A5; rs1_addr = 5'd7; rs2_addr = 5'd5;
      push(K_RET, 32'd10, "retire_is_10");
      push(K_RS1, 32'hA5A5A5A5, "reset_cycle_bypass_x7");
      tick();
      reset = 1'b0; RegWrite = 1'b0; Curr_Instr = 32'd0;
      for (int i = 0; i < 3; i++) begin
         push(K_RS1, 32'd0, $sformatf("after_reset_x7_%0d", i));
         push(K_RS2, 32'd0, $sformatf("after_reset_x5_%0d", i));
         push(K_RET, 32'd0, $sformatf("bubble_retire_%0d", i));
         tick();
      end

      // Give the monitor time to drain, then confirm nothing was left unchecked.
      tick();
      tick();
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending checks, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
